pcpi_insn_loader: RTL and testbench

Upstream feeder for the fused matrix-multiply PCPI coprocessor. It assembles a 32-bit instruction from eight 4-bit nibbles on the slow, asynchronous TinyTapeout input pins. It issues that instruction on the PCPI valid/ready handshake with a picorv32-style timeout. When the coprocessor writes a result, the block streams `pcpi_rd` back out as nibbles under the same strobe.

---
 rtl/pcpi_insn_loader.sv | 150 +++++++++++++++
 tb/tb_pcpi_insn_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pcpi_insn_loader.sv
// rtl/pcpi_insn_loader.sv - nibble-serial instruction loader and result drain for a PCPI coprocessor
// Strobe is synchronized, edge-detected, and drives a COLLECT/ISSUE/DRAIN state machine.
module pcpi_insn_loader #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  nib_in,
  input  logic        nib_strobe,
  output logic        busy,
  output logic [2:0]  nib_count,
  output logic        err,
  output logic [3:0]  res_nib,
  output logic        res_valid,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  input  logic        pcpi_ready,
  input  logic        pcpi_wr,
  input  logic        pcpi_wait,
  input  logic [31:0] pcpi_rd
);

  typedef enum logic [1:0] {COLLECT, ISSUE, DRAIN} state_t;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state_q, state_d;
  logic          s1_q, s2_q, s3_q;
  logic [2:0]    nib_count_q, nib_count_d;
  logic [31:0]   insn_q, insn_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0]   result_q, result_d;
  logic [2:0]    rcnt_q, rcnt_d;
  logic [2:0]    rcnt_next;
  logic          res_valid_q, res_valid_d;
  logic [3:0]    res_nib_q, res_nib_d;
  logic          strobe_edge;

  // Two-flop synchronizer plus a delay flop gives one edge per pulse
  assign strobe_edge = s2_q & ~s3_q;
  assign rcnt_next   = rcnt_q + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      state_q     <= COLLECT;
      nib_count_q <= 3'd0;
      insn_q      <= 32'd0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      timer_q     <= '0;
      result_q    <= 32'd0;
      rcnt_q      <= 3'd0;
      res_valid_q <= 1'b0;
      res_nib_q   <= 4'd0;
    end else begin
      s1_q        <= nib_strobe;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      state_q     <= state_d;
      nib_count_q <= nib_count_d;
      insn_q      <= insn_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      timer_q     <= timer_d;
      result_q    <= result_d;
      rcnt_q      <= rcnt_d;
      res_valid_q <= res_valid_d;
      res_nib_q   <= res_nib_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    nib_count_d = nib_count_q;
    insn_d      = insn_q;
    valid_d     = valid_q;
    err_d       = err_q;
    timer_d     = timer_q;
    result_d    = result_q;
    rcnt_d      = rcnt_q;
    res_valid_d = res_valid_q;
    res_nib_d   = res_nib_q;
    case (state_q)
      COLLECT: begin
        if (strobe_edge) begin
          insn_d[4*nib_count_q +: 4] = nib_in;
          if (nib_count_q == 3'd0) err_d = 1'b0;
          if (nib_count_q == 3'd7) begin
            nib_count_d = 3'd0;
            valid_d     = 1'b1;
            timer_d     = '0;
            state_d     = ISSUE;
          end else begin
            nib_count_d = nib_count_q + 3'd1;
          end
        end
      end
      ISSUE: begin
        // Ready takes priority over a coincident timeout
        if (pcpi_ready) begin
          valid_d = 1'b0;
          if (pcpi_wr) begin
            result_d    = pcpi_rd;
            res_valid_d = 1'b1;
            res_nib_d   = pcpi_rd[3:0];
            rcnt_d      = 3'd0;
            state_d     = DRAIN;
          end else begin
            state_d = COLLECT;
          end
        end else if (pcpi_wait) begin
          timer_d = '0;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          valid_d = 1'b0;
          err_d   = 1'b1;
          state_d = COLLECT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DRAIN: begin
        if (strobe_edge) begin
          if (rcnt_q == 3'd7) begin
            res_valid_d = 1'b0;
            rcnt_d      = 3'd0;
            res_nib_d   = 4'd0;
            state_d     = COLLECT;
          end else begin
            rcnt_d    = rcnt_next;
            res_nib_d = result_q[4*rcnt_next +: 4];
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  assign busy       = (state_q != COLLECT);
  assign nib_count  = nib_count_q;
  assign err        = err_q;
  assign res_nib    = res_nib_q;
  assign res_valid  = res_valid_q;
  assign pcpi_valid = valid_q;
  assign pcpi_insn  = insn_q;

endmodule

// File: tb/tb_pcpi_insn_loader.sv
// tb/tb_pcpi_insn_loader.sv - directed self-checking bench for pcpi_insn_loader
module tb_pcpi_insn_loader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  nib_in;
  logic        nib_strobe;
  logic        busy;
  logic [2:0]  nib_count;
  logic        err;
  logic [3:0]  res_nib;
  logic        res_valid;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic        pcpi_ready;
  logic        pcpi_wr;
  logic        pcpi_wait;
  logic [31:0] pcpi_rd;

  int total = 0;
  int bad   = 0;

  pcpi_insn_loader #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .nib_in(nib_in), .nib_strobe(nib_strobe),
    .busy(busy), .nib_count(nib_count), .err(err), .res_nib(res_nib),
    .res_valid(res_valid), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_ready(pcpi_ready), .pcpi_wr(pcpi_wr), .pcpi_wait(pcpi_wait),
    .pcpi_rd(pcpi_rd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nib_in = 4'd0; nib_strobe = 1'b0; pcpi_ready = 1'b0; pcpi_wr = 1'b0;
    pcpi_wait = 1'b0; pcpi_rd = 32'd0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic strobe(input logic [3:0] n, input int hi_cycles);
    nib_in = n;
    nib_strobe = 1'b1;
    repeat (hi_cycles) tick();
    nib_strobe = 1'b0;
    repeat (4) tick();
  endtask

  task automatic load_word(input logic [31:0] w);
    for (int i = 0; i < 8; i++) strobe(w[4*i +: 4], 4);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({busy, nib_count, err, res_nib, res_valid, pcpi_valid, pcpi_insn} !== 43'd0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b cnt=%0d err=%b rn=%h rv=%b v=%b insn=%h, want all 0",
               busy, nib_count, err, res_nib, res_valid, pcpi_valid, pcpi_insn);
    end
  endtask

  task automatic test_load_with_result();
    logic [31:0] rd;
    rd = 32'hCAFEF00D;
    do_reset();
    load_word(32'h1234ABCD);
    pcpi_wait = 1'b1;
    total++;
    if (pcpi_insn !== 32'h1234ABCD || pcpi_valid !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL load_insn: got insn=%h v=%b busy=%b, want 1234abcd 1 1", pcpi_insn, pcpi_valid, busy);
    end
    repeat (3) tick();
    pcpi_wait = 1'b0; pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = rd;
    total++;
    if (pcpi_valid !== 1'b1) begin
      bad++;
      $display("FAIL valid_before_ready: got %b want 1", pcpi_valid);
    end
    tick();
    pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = 32'd0;
    total++;
    if (pcpi_valid !== 1'b0 || res_valid !== 1'b1 || res_nib !== 4'hD) begin
      bad++;
      $display("FAIL ready_edge: got v=%b rv=%b rn=%h, want 0 1 d", pcpi_valid, res_valid, res_nib);
    end
    for (int i = 1; i < 8; i++) begin
      strobe(4'h0, 4);
      total++;
      if (res_nib !== rd[4*i +: 4] || res_valid !== 1'b1) begin
        bad++;
        $display("FAIL drain_nib%0d: got %h rv=%b, want %h 1", i, res_nib, res_valid, rd[4*i +: 4]);
      end
    end
    strobe(4'h0, 4);
    total++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || res_nib !== 4'h0 || nib_count !== 3'd0) begin
      bad++;
      $display("FAIL drain_end: got busy=%b rv=%b rn=%h cnt=%0d, want 0 0 0 0", busy, res_valid, res_nib, nib_count);
    end
  endtask

  task automatic test_ready_no_write();
    int rv_seen;
    do_reset();
    load_word(32'h0000_1111);
    pcpi_ready = 1'b1; pcpi_wr = 1'b0; pcpi_rd = 32'hFFFF_FFFF;
    tick();
    pcpi_ready = 1'b0; pcpi_rd = 32'd0;
    rv_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (res_valid) rv_seen++;
      tick();
    end
    total++;
    if (pcpi_valid !== 1'b0 || busy !== 1'b0 || rv_seen != 0) begin
      bad++;
      $display("FAIL ready_no_wr: got v=%b busy=%b rv_cycles=%0d, want 0 0 0", pcpi_valid, busy, rv_seen);
    end
  endtask

  task automatic test_timeout();
    int hi;
    int seen;
    do_reset();
    for (int i = 0; i < 7; i++) strobe(4'h5, 4);
    nib_in = 4'h9;
    nib_strobe = 1'b1;
    hi = 0; seen = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (c == 3) nib_strobe = 1'b0;
      if (pcpi_valid) begin hi++; seen = 1; end
      else if (seen != 0) break;
    end
    total++;
    if (hi != 16) begin
      bad++;
      $display("FAIL timeout_len: got %0d cycles want 16", hi);
    end
    total++;
    if (err !== 1'b1 || busy !== 1'b0 || pcpi_valid !== 1'b0) begin
      bad++;
      $display("FAIL timeout_flags: got err=%b busy=%b v=%b, want 1 0 0", err, busy, pcpi_valid);
    end
    repeat (3) tick();
    strobe(4'h2, 4);
    total++;
    if (err !== 1'b0 || nib_count !== 3'd1) begin
      bad++;
      $display("FAIL err_clear: got err=%b cnt=%0d, want 0 1", err, nib_count);
    end
  endtask

  task automatic test_long_wait();
    do_reset();
    pcpi_wait = 1'b1;
    load_word(32'h0BAD_F00D);
    repeat (40) tick();
    total++;
    if (pcpi_valid !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL long_wait_hold: got v=%b err=%b, want 1 0", pcpi_valid, err);
    end
    pcpi_wait = 1'b0; pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'h0000_0007;
    tick();
    pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = 32'd0;
    total++;
    if (res_nib !== 4'h7 || res_valid !== 1'b1 || err !== 1'b0 || pcpi_valid !== 1'b0) begin
      bad++;
      $display("FAIL long_wait_result: got rn=%h rv=%b err=%b v=%b, want 7 1 0 0", res_nib, res_valid, err, pcpi_valid);
    end
  endtask

  task automatic test_reset_mid_collect();
    do_reset();
    for (int i = 0; i < 5; i++) strobe(4'hF, 4);
    total++;
    if (nib_count !== 3'd5) begin
      bad++;
      $display("FAIL mid_count: got %0d want 5", nib_count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (nib_count !== 3'd0 || pcpi_insn !== 32'd0 || busy !== 1'b0 || pcpi_valid !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got cnt=%0d insn=%h busy=%b v=%b, want 0 0 0 0", nib_count, pcpi_insn, busy, pcpi_valid);
    end
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) strobe(4'(i), 4);
    total++;
    if (pcpi_insn !== 32'h76543210 || pcpi_valid !== 1'b1) begin
      bad++;
      $display("FAIL reload_insn: got %h v=%b, want 76543210 1", pcpi_insn, pcpi_valid);
    end
  endtask

  task automatic test_strobe_robustness();
    logic [31:0] held;
    do_reset();
    strobe(4'hA, 10);
    total++;
    if (nib_count !== 3'd1 || pcpi_insn[3:0] !== 4'hA) begin
      bad++;
      $display("FAIL long_strobe: got cnt=%0d nib0=%h, want 1 a", nib_count, pcpi_insn[3:0]);
    end
    pcpi_wait = 1'b1;
    for (int i = 1; i < 8; i++) strobe(4'(i), 4);
    held = pcpi_insn;
    strobe(4'hE, 4);
    strobe(4'hE, 4);
    total++;
    if (nib_count !== 3'd0 || pcpi_insn !== 32'h7654321A || held !== 32'h7654321A || busy !== 1'b1) begin
      bad++;
      $display("FAIL issue_strobes: got cnt=%0d insn=%h busy=%b, want 0 7654321a 1", nib_count, pcpi_insn, busy);
    end
    pcpi_wait = 1'b0; pcpi_ready = 1'b1;
    tick();
    pcpi_ready = 1'b0;
    total++;
    if (busy !== 1'b0 || pcpi_insn !== 32'h7654321A) begin
      bad++;
      $display("FAIL insn_kept: got busy=%b insn=%h, want 0 7654321a", busy, pcpi_insn);
    end
  endtask

  initial begin
    test_reset();
    test_load_with_result();
    test_ready_no_write();
    test_timeout();
    test_long_wait();
    test_reset_mid_collect();
    test_strobe_robustness();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
